// File: rtl/seq_tracker.sv
// seq_tracker: receive-side checker for the 3-bit sequenced counter.
// It locks onto the cycle 000->110->100->111->011->000, reports the cycle position,
// flags out-of-sequence samples and keeps a saturating error count.
// Optional feature macro: SEQ_TRACK_ILLEGAL_EN adds an 'illegal' pulse output, and
// an illegal code seen while locked then forces an immediate return to HUNT.
// Handshake: 'valid' qualifies 'code' for one cycle. There is no backpressure, so
// every valid cycle is consumed, and all outputs update on the following edge.
module seq_tracker #(
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [2:0]       code,
  input  logic             err_clr,
  output logic             locked,
  output logic [2:0]       index,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
`ifdef SEQ_TRACK_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {HUNT = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       good_q, good_d;
  logic [2:0]       miss_q, miss_d;
  logic [2:0]       index_q, index_d;
  logic             mismatch_q, mismatch_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       legal;
  logic       hit;
  logic       drop_now;
  logic [2:0] exp_code;
  logic [3:0] good_inc;
  logic [3:0] miss_inc;

  // Successor of a code in the counter cycle.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  next_code = 3'b110;
      3'b110:  next_code = 3'b100;
      3'b100:  next_code = 3'b111;
      3'b111:  next_code = 3'b011;
      3'b011:  next_code = 3'b000;
      default: next_code = 3'b000;
    endcase
  endfunction

  // Position of a code within the cycle.
  function automatic logic [2:0] code_pos(input logic [2:0] c);
    case (c)
      3'b110:  code_pos = 3'd1;
      3'b100:  code_pos = 3'd2;
      3'b111:  code_pos = 3'd3;
      3'b011:  code_pos = 3'd4;
      default: code_pos = 3'd0;
    endcase
  endfunction

  // Next-state logic: acquisition, flywheel tracking and error counting.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    miss_d     = miss_q;
    index_d    = index_q;
    mismatch_d = 1'b0;
    illegal_d  = 1'b0;
    err_d      = err_q;

    legal    = (code != 3'b001) && (code != 3'b010) && (code != 3'b101);
    exp_code = next_code(prev_q);
    hit      = legal && (code == exp_code);
    good_inc = {1'b0, good_q} + 4'd1;
    miss_inc = {1'b0, miss_q} + 4'd1;
`ifdef SEQ_TRACK_ILLEGAL_EN
    drop_now = !legal;
`else
    drop_now = 1'b0;
`endif

    if (valid) begin
      illegal_d = !legal;
      case (state_q)
        HUNT: begin
          if (legal) begin
            prev_d  = code;
            good_d  = 3'd0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (hit) begin
            prev_d = code;
            good_d = good_inc[2:0];
            if (good_inc == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              index_d = code_pos(code);
              miss_d  = 3'd0;
            end
          end else begin
            prev_d = code;
            good_d = 3'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            prev_d  = code;
            index_d = code_pos(code);
            miss_d  = 3'd0;
          end else begin
            // Flywheel: assume the counter advanced even though the sample was bad.
            mismatch_d = 1'b1;
            miss_d     = miss_inc[2:0];
            prev_d     = exp_code;
            index_d    = code_pos(exp_code);
            if ((miss_inc == 4'(MISS_MAX)) || drop_now) begin
              state_d = HUNT;
              index_d = 3'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          index_d = 3'd0;
        end
      endcase
    end

    // A clear coinciding with a mismatch keeps that mismatch counted.
    if (err_clr) begin
      err_d = mismatch_d ? ERR_W'(1) : '0;
    end else if (mismatch_d && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      prev_q     <= 3'd0;
      good_q     <= 3'd0;
      miss_q     <= 3'd0;
      index_q    <= 3'd0;
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      index_q    <= index_d;
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign index     = index_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;
  assign state_dbg = state_q;
`ifdef SEQ_TRACK_ILLEGAL_EN
  assign illegal   = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_seq_tracker.sv
// Bench for seq_tracker: a default-width instance and an ERR_W=2 instance share
// the same stimulus; a position-based reference model fills the expected queue.
module tb_seq_tracker;

  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 2;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [2:0] code;
  logic       err_clr;

  logic       locked8, locked2;
  logic [2:0] index8, index2;
  logic       mismatch8, mismatch2;
  logic [7:0] err8;
  logic [1:0] err2;
  logic [1:0] dbg8, dbg2;
  logic       ill8, ill2;

  seq_tracker #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ERR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .code(code), .err_clr(err_clr),
    .locked(locked8), .index(index8), .mismatch(mismatch8), .err_cnt(err8),
`ifdef SEQ_TRACK_ILLEGAL_EN
    .illegal(ill8),
`endif
    .state_dbg(dbg8)
  );

  seq_tracker #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .code(code), .err_clr(err_clr),
    .locked(locked2), .index(index2), .mismatch(mismatch2), .err_cnt(err2),
`ifdef SEQ_TRACK_ILLEGAL_EN
    .illegal(ill2),
`endif
    .state_dbg(dbg2)
  );

`ifndef SEQ_TRACK_ILLEGAL_EN
  assign ill8 = 1'b0;
  assign ill2 = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] seq_tab [5];
  initial begin
    seq_tab[0] = 3'b000; seq_tab[1] = 3'b110; seq_tab[2] = 3'b100;
    seq_tab[3] = 3'b111; seq_tab[4] = 3'b011;
  end

  int m_state;   // 0 hunt, 1 acquire, 2 locked
  int m_prev;    // position of last accepted/flywheeled code
  int m_good, m_miss, m_idx, m_err8, m_err2;
  logic [15:0] exp_q [$];

  function automatic int pos_of(input logic [2:0] c);
    pos_of = -1;
    for (int i = 0; i < 5; i++) if (seq_tab[i] == c) pos_of = i;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_good = 0; m_miss = 0; m_idx = 0;
    m_err8 = 0; m_err2 = 0;
  endtask

  // Advance the model by one clock with the given inputs and return the outputs.
  task automatic model_step(input logic v, input logic [2:0] c, input logic clr,
                            output logic [15:0] word);
    int  p;
    logic mis, ill;
    bit  ill_en;
`ifdef SEQ_TRACK_ILLEGAL_EN
    ill_en = 1;
`else
    ill_en = 0;
`endif
    mis = 0; ill = 0;
    p = pos_of(c);
    if (v) begin
      ill = ill_en && (p < 0);
      if (m_state == 0) begin
        if (p >= 0) begin m_prev = p; m_good = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (p < 0) m_state = 0;
        else if (p == (m_prev + 1) % 5) begin
          m_prev = p; m_good++;
          if (m_good == LOCK_CNT) begin m_state = 2; m_idx = p; m_miss = 0; end
        end else begin
          m_prev = p; m_good = 0;
        end
      end else begin
        if (p >= 0 && p == (m_prev + 1) % 5) begin
          m_prev = p; m_idx = p; m_miss = 0;
        end else begin
          mis = 1; m_miss++;
          m_prev = (m_prev + 1) % 5; m_idx = m_prev;
          if (m_miss == MISS_MAX || (ill_en && p < 0)) begin m_state = 0; m_idx = 0; end
        end
      end
    end
    if (clr) begin
      m_err8 = mis ? 1 : 0; m_err2 = mis ? 1 : 0;
    end else if (mis) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3)   m_err2++;
    end
    word = {ill, (m_state == 2) ? 1'b1 : 1'b0, 3'(m_idx), mis, 8'(m_err8), 2'(m_err2)};
  endtask

  // ---------------- drivers ----------------
  int g;  // bench-side position of the last code the generator emitted

  task automatic send(input logic v, input logic [2:0] c, input logic clr);
    logic [15:0] w, e;
    @(negedge clk);
    valid = v; code = c; err_clr = clr;
    model_step(v, c, clr, w);
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("locked",   {15'd0, locked8},   {15'd0, e[14]});
    check("index",    {13'd0, index8},    {13'd0, e[13:11]});
    check("mismatch", {15'd0, mismatch8}, {15'd0, e[10]});
    check("err8",     {8'd0, err8},       {8'd0, e[9:2]});
    check("err2",     {14'd0, err2},      {14'd0, e[1:0]});
    check("locked2",  {15'd0, locked2},   {15'd0, e[14]});
`ifdef SEQ_TRACK_ILLEGAL_EN
    check("illegal",  {15'd0, ill8},      {15'd0, e[15]});
`endif
    valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_good();
    g = (g + 1) % 5;
    send(1'b1, seq_tab[g], 1'b0);
  endtask

  task automatic send_bad();
    send(1'b1, seq_tab[(g + 3) % 5], 1'b0);
    g = (g + 1) % 5;
  endtask

  task automatic relock();
    for (int i = 0; i < LOCK_CNT + 1; i++) send_good();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst_n = 1'b0; valid = 1'b0; code = 3'b000; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {15'd0, locked8}, 16'd0);
    check("rst_index",  {13'd0, index8},  16'd0);
    check("rst_err",    {8'd0, err8},     16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: acquire from 000 and lock one cycle after 111
    g = 4;
    relock();
    check("t1_locked", {15'd0, locked8}, 16'd1);
    check("t1_index",  {13'd0, index8},  16'd3);

    // 2: wrong 000 where 011 expected, then 000 is correct again
    send(1'b1, 3'b000, 1'b0); g = 4;
    check("t2_err", {8'd0, err8}, 16'd1);
    check("t2_idx", {13'd0, index8}, 16'd4);
    send_good();
    check("t2_wrap", {13'd0, index8}, 16'd0);

    // 3: two consecutive misses drop lock
    send_bad(); send_bad();
    check("t3_unlock", {15'd0, locked8}, 16'd0);

    // 4: valid gaps with junk code hold everything
    relock();
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      send_good();
    end

    // 5: saturation in the narrow counter, then the two clear cases
    send(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) begin send_bad(); send_good(); end
    check("t5_sat", {14'd0, err2}, 16'd3);
    send_bad();
    send(1'b1, seq_tab[(g + 3) % 5], 1'b1); g = (g + 1) % 5;
    check("t5_clr_mis", {14'd0, err2}, 16'd1);
    send(1'b0, 3'b000, 1'b1);
    check("t5_clr", {8'd0, err8}, 16'd0);

    // 6: asynchronous reset mid-lock, then an illegal code while locked
    relock(); relock();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_locked", {15'd0, locked8},   16'd0);
    check("t6_async_index",  {13'd0, index8},    16'd0);
    check("t6_async_err",    {14'd0, err2},      16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    relock();
    send(1'b1, 3'b101, 1'b0);
    g = (g + 1) % 5;

    // Random mix of in-sequence, corrupt and idle samples.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        send(1'b0, 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      end else if ($urandom_range(0, 9) < 8) begin
        g = (g + 1) % 5;
        send(1'b1, seq_tab[g], ($urandom_range(0, 19) == 0));
      end else begin
        g = (g + 1) % 5;
        send(1'b1, 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
